circ_queue: RTL and testbench
=============================

Name: circ_queue

Overview:
- Parametrised circular queue (FIFO); the next generation of the team's single-bit load/reset register cells.
- Storage is DEPTH words of WIDTH bits, with read/write pointers that wrap around, occupancy count, full/empty flags and a synchronous flush.
- Sits between producer and consumer logic in the same clock domain.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, number of entries (>=2; need not be a power of 2).
- CW, $clog2(DEPTH+1), width of the count output (derived, not overridden).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset_  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous flush, active-high.
- push  input  1  write request.
- din  input  WIDTH  write data, sampled on an accepted push.
- pop  input  1  read request.
- dout  output  WIDTH  head entry of the queue.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  CW  number of valid entries.

Behaviour:
- Reset (reset_ = 0, asynchronous, no clock needed):
  - wr_ptr, rd_ptr and count go to 0; all storage words go to 0.
  - Outputs: empty = 1, full = 0, count = 0, dout = 0.
  - Release of reset_ is synchronous to the next clk edge.
- Accept rules, evaluated each rising clk edge:
  - push_ok = push & (!full | pop).
  - pop_ok = pop & !empty.
- Accepted push: mem[wr_ptr] <= din; wr_ptr advances by 1 and wraps from DEPTH-1 to 0.
- Accepted pop: rd_ptr advances by 1 with the same wrap.
- Count update:
  - push_ok only: count + 1.
  - pop_ok only: count - 1.
  - Both: count unchanged.
  - Neither: hold.
- Full with push and pop together: both are accepted; the head is read out and the new word is written into the freed slot; count stays DEPTH.
- Empty with push and pop together: the pop is ignored (no fall-through); the push is accepted; count becomes 1.
- Push while full without pop: dropped. Storage, pointers and count are unchanged.
- Pop while empty: ignored.
- clr = 1: pointers and count go to 0 at the edge. clr has priority over push and pop in the same cycle. Storage contents are not cleared.
- dout: combinational view of mem[rd_ptr] when !empty; forced to 0 when empty.
  - Latency: a word pushed at edge N is visible on dout after edge N if the queue was empty.
- full, empty and count are registered-state derived. They change only on a clk edge or on asynchronous reset.
- Mid-operation reset: any in-flight push or pop is abandoned and the state returns to the reset values above.
- Arithmetic: pointers are $clog2(DEPTH) bits with explicit wrap compare, not modulo-2^n.

Optional Feature:
- Macro: CIRC_QUEUE_ERR_FLAGS_EN.
- When defined, adds two outputs:
  - ovf (1 bit): sets on any push while full without pop.
  - udf (1 bit): sets on any pop while empty, including the push+pop-on-empty case.
- Both flags are sticky and cleared only by reset_ = 0 or clr = 1. Reset value is 0.
- When not defined, the ports and their logic are absent; all other behaviour is identical.

Test Plan (WIDTH = 8, DEPTH = 4):
- Reset check: assert reset_ = 0 mid-clock -> immediately empty = 1, full = 0, count = 0, dout = 0x00.
- Fill to full: push 0x11, 0x22, 0x33, 0x44 -> count = 4, full = 1, dout = 0x11. A 5th push of 0x55 is dropped; ovf = 1 if CIRC_QUEUE_ERR_FLAGS_EN.
- Wrap-around: after fill, pop 2, push 0xA0, 0xA1, pop 4 -> dout sequence 0x33, 0x44, 0xA0, 0xA1; empty = 1 at the end.
- Simultaneous push+pop when full, with din = 0x66 -> dout steps from 0x11 to 0x22; count stays 4; 0x66 later emerges after 0x44.
- Push+pop when empty, with din = 0x77 -> count = 1, dout = 0x77; udf = 1 if the macro is defined.
- clr with push and pop all asserted while count = 3 -> next cycle count = 0, empty = 1, dout = 0x00; ovf and udf cleared.

Source files
------------

// File: rtl/circ_queue.sv
// Parametrised circular queue (FIFO) with wrapping read/write pointers, occupancy count and synchronous flush.
// Optional sticky overflow/underflow flags are enabled by defining CIRC_QUEUE_ERR_FLAGS_EN.
module circ_queue #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
`ifdef CIRC_QUEUE_ERR_FLAGS_EN
   ,
   output logic             ovf,
   output logic             udf
`endif
);

   localparam int             PW       = $clog2(DEPTH);
   localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic             w_full;
   logic             w_empty;
   logic             w_push_ok;
   logic             w_pop_ok;

   // Pointers wrap by explicit compare so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
      logic [PW-1:0] nxt;
      if (ptr == LAST_PTR) begin
         nxt = {PW{1'b0}};
      end else begin
         nxt = ptr + PW'(1);
      end
      return nxt;
   endfunction

   // Status flags and accept decisions from the registered state.
   always_comb begin
      w_full    = (r_count == FULL_CNT);
      w_empty   = (r_count == {CW{1'b0}});
      w_push_ok = push & (~w_full | pop);
      w_pop_ok  = pop & ~w_empty;
   end

   // Pointer and occupancy state; flush wins over push and pop.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_wr_ptr <= {PW{1'b0}};
         r_rd_ptr <= {PW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else if (clr) begin
         r_wr_ptr <= {PW{1'b0}};
         r_rd_ptr <= {PW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage array; a flush leaves the words in place.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {WIDTH{1'b0}};
         end
      end else if (w_push_ok && !clr) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // Head word shown directly; no fall-through of a same-cycle push.
   always_comb begin
      if (w_empty) begin
         dout = {WIDTH{1'b0}};
      end else begin
         dout = r_mem[r_rd_ptr];
      end
      full  = w_full;
      empty = w_empty;
      count = r_count;
   end

`ifdef CIRC_QUEUE_ERR_FLAGS_EN
   logic r_ovf;
   logic r_udf;

   // Sticky error flags, cleared only by reset or flush.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else if (clr) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (push && w_full && !pop) begin
            r_ovf <= 1'b1;
         end
         if (pop && w_empty) begin
            r_udf <= 1'b1;
         end
      end
   end

   assign ovf = r_ovf;
   assign udf = r_udf;
`endif

endmodule

// File: tb/tb_circ_queue.sv
// Self-checking bench for circ_queue (WIDTH=8, DEPTH=4): directed vector table plus randomized traffic
// against a queue-based reference model. Flag checks are active when CIRC_QUEUE_ERR_FLAGS_EN is defined.
module tb_circ_queue;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk;
   logic             reset_;
   logic             clr;
   logic             push;
   logic [WIDTH-1:0] din;
   logic             pop;
   logic [WIDTH-1:0] dout;
   logic             full;
   logic             empty;
   logic [CW-1:0]    count;
`ifdef CIRC_QUEUE_ERR_FLAGS_EN
   logic             ovf;
   logic             udf;
`endif

   circ_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk    (clk),
      .reset_ (reset_),
      .clr    (clr),
      .push   (push),
      .din    (din),
      .pop    (pop),
      .dout   (dout),
      .full   (full),
      .empty  (empty),
      .count  (count)
`ifdef CIRC_QUEUE_ERR_FLAGS_EN
      ,
      .ovf    (ovf),
      .udf    (udf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       clr;
      logic       push;
      logic       pop;
      logic [7:0] din;
      logic [2:0] cnt;
      logic [7:0] dout;
      logic       full;
      logic       empty;
      logic       ovf;
      logic       udf;
   } vec_t;

   vec_t vq[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: contents as a plain queue, plus sticky flags.
   int   mq[$];
   bit   m_ovf = 1'b0;
   bit   m_udf = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic c, input logic p, input logic o, input logic [7:0] d,
                      input logic [2:0] n, input logic [7:0] q, input logic f, input logic e,
                      input logic ov, input logic ud);
      vec_t v;
      v.clr = c; v.push = p; v.pop = o; v.din = d;
      v.cnt = n; v.dout = q; v.full = f; v.empty = e; v.ovf = ov; v.udf = ud;
      vq.push_back(v);
   endtask

   task automatic check_flags(input string tag, input bit eo, input bit eu);
`ifdef CIRC_QUEUE_ERR_FLAGS_EN
      check({tag, " ovf"}, {31'd0, ovf}, {31'd0, eo});
      check({tag, " udf"}, {31'd0, udf}, {31'd0, eu});
`endif
   endtask

   // Called at a negedge: drive, take one rising edge, return at the next negedge.
   task automatic step(input logic c, input logic p, input logic o, input logic [7:0] d);
      clr = c; push = p; pop = o; din = d;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_step(input bit c, input bit p, input bit o, input int d);
      bit is_full, is_empty, pok, ook;
      if (c) begin
         mq.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         is_full  = (mq.size() == DEPTH);
         is_empty = (mq.size() == 0);
         if (p && is_full && !o) m_ovf = 1'b1;
         if (o && is_empty) m_udf = 1'b1;
         pok = p && (!is_full || o);
         ook = o && !is_empty;
         if (ook) void'(mq.pop_front());
         if (pok) mq.push_back(d);
      end
   endtask

   task automatic check_model(input string tag);
      int exp_dout;
      exp_dout = (mq.size() > 0) ? mq[0] : 0;
      check({tag, " count"}, 32'(count), 32'(mq.size()));
      check({tag, " dout"},  32'(dout),  32'(exp_dout));
      check({tag, " full"},  {31'd0, full},  {31'd0, mq.size() == DEPTH});
      check({tag, " empty"}, {31'd0, empty}, {31'd0, mq.size() == 0});
      check_flags(tag, m_ovf, m_udf);
   endtask

   // Asserts reset away from a clock edge, checks immediate outputs, releases at a negedge.
   task automatic do_reset(input string tag);
      #2;
      reset_ = 1'b0;
      #1;
      check({tag, " rst empty"}, {31'd0, empty}, 32'd1);
      check({tag, " rst full"},  {31'd0, full},  32'd0);
      check({tag, " rst count"}, 32'(count), 32'd0);
      check({tag, " rst dout"},  32'(dout),  32'd0);
      check_flags({tag, " rst"}, 1'b0, 1'b0);
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0; push = 1'b0; pop = 1'b0;
      reset_ = 1'b1;
   endtask

   initial begin
      reset_ = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; din = 8'h00;
      #3;
      check("init empty", {31'd0, empty}, 32'd1);
      check("init count", 32'(count), 32'd0);
      check("init dout",  32'(dout),  32'd0);
      @(negedge clk);
      reset_ = 1'b1;
      @(negedge clk);

      // Directed table: clr push pop din | count dout full empty ovf udf
      add(1'b0,1'b1,1'b0,8'h11, 3'd1,8'h11,1'b0,1'b0, 1'b0,1'b0);
      add(1'b0,1'b1,1'b0,8'h22, 3'd2,8'h11,1'b0,1'b0, 1'b0,1'b0);
      add(1'b0,1'b1,1'b0,8'h33, 3'd3,8'h11,1'b0,1'b0, 1'b0,1'b0);
      add(1'b0,1'b1,1'b0,8'h44, 3'd4,8'h11,1'b1,1'b0, 1'b0,1'b0);
      add(1'b0,1'b1,1'b0,8'h55, 3'd4,8'h11,1'b1,1'b0, 1'b1,1'b0);
      add(1'b0,1'b1,1'b1,8'h66, 3'd4,8'h22,1'b1,1'b0, 1'b1,1'b0);
      add(1'b0,1'b0,1'b1,8'h00, 3'd3,8'h33,1'b0,1'b0, 1'b1,1'b0);
      add(1'b0,1'b0,1'b1,8'h00, 3'd2,8'h44,1'b0,1'b0, 1'b1,1'b0);
      add(1'b0,1'b0,1'b1,8'h00, 3'd1,8'h66,1'b0,1'b0, 1'b1,1'b0);
      add(1'b0,1'b0,1'b1,8'h00, 3'd0,8'h00,1'b0,1'b1, 1'b1,1'b0);
      add(1'b0,1'b0,1'b1,8'h00, 3'd0,8'h00,1'b0,1'b1, 1'b1,1'b1);
      add(1'b0,1'b1,1'b1,8'h77, 3'd1,8'h77,1'b0,1'b0, 1'b1,1'b1);
      add(1'b0,1'b0,1'b1,8'h00, 3'd0,8'h00,1'b0,1'b1, 1'b1,1'b1);
      add(1'b0,1'b1,1'b0,8'h11, 3'd1,8'h11,1'b0,1'b0, 1'b1,1'b1);
      add(1'b0,1'b1,1'b0,8'h22, 3'd2,8'h11,1'b0,1'b0, 1'b1,1'b1);
      add(1'b0,1'b1,1'b0,8'h33, 3'd3,8'h11,1'b0,1'b0, 1'b1,1'b1);
      add(1'b0,1'b1,1'b0,8'h44, 3'd4,8'h11,1'b1,1'b0, 1'b1,1'b1);
      add(1'b0,1'b0,1'b1,8'h00, 3'd3,8'h22,1'b0,1'b0, 1'b1,1'b1);
      add(1'b0,1'b0,1'b1,8'h00, 3'd2,8'h33,1'b0,1'b0, 1'b1,1'b1);
      add(1'b0,1'b1,1'b0,8'hA0, 3'd3,8'h33,1'b0,1'b0, 1'b1,1'b1);
      add(1'b0,1'b1,1'b0,8'hA1, 3'd4,8'h33,1'b1,1'b0, 1'b1,1'b1);
      add(1'b0,1'b0,1'b1,8'h00, 3'd3,8'h44,1'b0,1'b0, 1'b1,1'b1);
      add(1'b0,1'b0,1'b1,8'h00, 3'd2,8'hA0,1'b0,1'b0, 1'b1,1'b1);
      add(1'b0,1'b0,1'b1,8'h00, 3'd1,8'hA1,1'b0,1'b0, 1'b1,1'b1);
      add(1'b0,1'b0,1'b1,8'h00, 3'd0,8'h00,1'b0,1'b1, 1'b1,1'b1);
      add(1'b0,1'b1,1'b0,8'h01, 3'd1,8'h01,1'b0,1'b0, 1'b1,1'b1);
      add(1'b0,1'b1,1'b0,8'h02, 3'd2,8'h01,1'b0,1'b0, 1'b1,1'b1);
      add(1'b0,1'b1,1'b0,8'h03, 3'd3,8'h01,1'b0,1'b0, 1'b1,1'b1);
      add(1'b1,1'b1,1'b1,8'h99, 3'd0,8'h00,1'b0,1'b1, 1'b0,1'b0);
      add(1'b0,1'b1,1'b0,8'h05, 3'd1,8'h05,1'b0,1'b0, 1'b0,1'b0);

      foreach (vq[i]) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         step(vq[i].clr, vq[i].push, vq[i].pop, vq[i].din);
         check({tag, " count"}, 32'(count), 32'(vq[i].cnt));
         check({tag, " dout"},  32'(dout),  32'(vq[i].dout));
         check({tag, " full"},  {31'd0, full},  {31'd0, vq[i].full});
         check({tag, " empty"}, {31'd0, empty}, {31'd0, vq[i].empty});
         check_flags(tag, vq[i].ovf, vq[i].udf);
      end

      // Mid-operation reset with a push in flight: the push is abandoned.
      step(1'b0, 1'b1, 1'b0, 8'hC1);
      push = 1'b1; din = 8'hC2;
      do_reset("midop");
      check_model("post-reset");

      // Randomized traffic against the reference model, push-heavy then pop-heavy.
      for (int i = 0; i < 600; i++) begin
         bit c, p, o;
         int d;
         c = ($urandom_range(0, 39) == 0);
         if (i < 300) begin
            p = ($urandom_range(0, 3) != 0);
            o = ($urandom_range(0, 3) == 0);
         end else begin
            p = ($urandom_range(0, 3) == 0);
            o = ($urandom_range(0, 3) != 0);
         end
         d = int'($urandom_range(0, 255));
         if (i == 450) begin
            push = p; pop = o; din = 8'(d);
            do_reset("rand");
         end else begin
            model_step(c, p, o, d);
            step(c, p, o, 8'(d));
            check_model($sformatf("rand%0d", i));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
